// File: rtl/fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side engine for the synchronous FIFO. It pulls words out of the FIFO
// through its rd_en/dout/empty port and presents them to a downstream consumer
// as a valid/ready stream. It accounts for the FIFO's one-cycle read latency
// with an "in flight" flag and keeps a small prefetch buffer. As a result the
// consumer sees back-to-back words, and there is no combinational path from
// out_ready to fifo_rd_en.
//
// Parameters
//   WIDTH      data width, equal to the FIFO data width
//   BUF_DEPTH  prefetch buffer entries (min 2; 3 or more sustains 1 word/cycle)
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active-high
//   fifo_empty  in   FIFO empty flag (registered inside the FIFO)
//   fifo_dout   in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  read strobe to the FIFO
//   flush       in   synchronous flush of buffered and in-flight words
//   out_data    out  stream data (buffer head)
//   out_valid   out  stream valid
//   out_ready   in   stream ready from the consumer
//   level       out  number of words currently held in the buffer
// ----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter  int WIDTH     = 8,
    parameter  int BUF_DEPTH = 3,
    localparam int LVL_W     = $clog2(BUF_DEPTH + 1),
    localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LVL_W-1:0] level
);

    localparam logic [LVL_W:0]   CAPACITY = (LVL_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    logic [WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [LVL_W-1:0] level_q;
    logic             inflight;

    logic             capture;
    logic             pop;
    logic [LVL_W:0]   occupancy;

    // Pointers wrap explicitly, so BUF_DEPTH does not have to be a power of 2.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // The word requested last cycle appears on fifo_dout now.
    assign capture   = inflight;
    assign pop       = out_valid && out_ready;

    // The credit check counts the in-flight word as well as the stored words.
    // A capture therefore always finds a free slot. It uses registered state
    // only, so out_ready never reaches fifo_rd_en. rst is included so that the
    // strobe drops at once on an asynchronous reset, without waiting for an edge.
    assign occupancy  = {1'b0, level_q} + {{LVL_W{1'b0}}, inflight};
    assign fifo_rd_en = !rst && !fifo_empty && !flush && (occupancy < CAPACITY);

    assign out_valid  = (level_q != '0);
    assign out_data   = buf_mem[head];
    assign level      = level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            level_q  <= '0;
            inflight <= 1'b0;
            // NOTE: the storage array is reset on purpose. out_data is read
            // straight from the head entry, and it must be 0 out of reset
            // instead of showing whatever value the flops power up with.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (flush) begin
            // Flush wins over capture and pop. The word arriving on fifo_dout
            // now is dropped. fifo_rd_en is low this cycle, so nothing is
            // left in flight afterwards.
            head     <= '0;
            tail     <= '0;
            level_q  <= '0;
            inflight <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignments. Every
            // register then sees the values from before the edge, which lets
            // capture and pop in the same cycle compose correctly.
            inflight <= fifo_rd_en;

            if (capture) begin
                buf_mem[tail] <= fifo_dout;
                tail          <= ptr_inc(tail);
            end

            if (pop) begin
                head <= ptr_inc(head);
            end

            // level is kept as its own counter. With pointers that wrap at a
            // depth that is not a power of two, deriving it from head/tail
            // is awkward.
            case ({capture, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Structural invariants of the credit scheme.
    a_no_read_when_empty : assert property (
        @(posedge clk) disable iff (rst) !(fifo_rd_en && fifo_empty));

    a_level_bounded : assert property (
        @(posedge clk) disable iff (rst) level_q <= LVL_W'(BUF_DEPTH));

    a_capture_has_room : assert property (
        @(posedge clk) disable iff (rst)
        !(capture && !pop && !flush && level_q == LVL_W'(BUF_DEPTH)));

endmodule
